seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//   Parametrised serial bit-pattern detector. It samples one bit per enabled clock and
//   tracks the longest matched prefix of PATTERN (the FSM state). It raises a one-cycle
//   registered match pulse and keeps a saturating match counter.
//   Generalises the fixed 4-state detector FSM: pattern, length, overlap mode and counter
//   width are parameters. Sits between a serial input stage and status/interrupt logic.
// PARAMETERS
//   N        4        pattern length in bits, N >= 2
//   PATTERN  4'b1011  pattern to detect; PATTERN[N-1] is the first bit received
//   OVERLAP  1        1 = overlapping matches allowed; 0 = state restarts at 0 after a match
//   CNT_W    8        width of match_count
// PORTS
//   clk          in   1              rising-edge clock
//   reset        in   1              asynchronous, active-low reset (0 = reset)
//   en           in   1              sample enable; in is ignored when en = 0
//   in           in   1              serial data bit
//   count_clr    in   1              synchronous clear of match_count
//   out          out  1              registered match pulse, one cycle wide
//   state        out  $clog2(N)      matched-prefix length, range 0..N-1
//   match_count  out  CNT_W          saturating count of matches
//   count_sat    out  1              high while match_count == 2^CNT_W-1
// BEHAVIOUR
//   - Reset (reset = 0, async): state = 0, out = 0, match_count = 0, count_sat = 0.
//     Reset mid-sequence discards the partial match. The first edge after release
//     samples normally.
//   - On each rising edge with en = 1, compute L = length of the longest prefix of
//     PATTERN that is a suffix of (the matched prefix of length state, followed by in).
//     This is the KMP transition, so there is no fixed state list.
//   - If L < N: state <= L, out <= 0.
//   - If L == N (match):
//     - out <= 1.
//     - state <= F(N) when OVERLAP = 1, where F(N) is the longest proper prefix of
//       PATTERN that is also its suffix.
//     - state <= 0 when OVERLAP = 0.
//   - en = 0: state holds, out <= 0, match_count holds.
//   - Latency: out is high in the cycle after the edge that sampled the completing bit.
//     Back-to-back matches give consecutive high cycles on out (possible only if F(N) = N-1).
//   - match_count:
//     - Increments by 1 on each match edge and saturates at 2^CNT_W-1 (never wraps).
//     - count_sat is combinational from match_count.
//   - count_clr = 1: match_count <= 0 on that edge. It takes priority over a
//     simultaneous match, so the count is 0, but out still pulses and state still advances.
//   - Transition table: N x 2 entries, resolved at elaboration by a constant function.
//     There is no runtime search logic.
//   - Illegal parameters (N < 2, PATTERN wider than N) are rejected at elaboration.
// STRUCTURE
//   - seq_det_pkg:
//     - constant function next_len(pattern, n, len, bit) returning L;
//     - constant function fail_len(pattern, n) returning F(N);
//     - state-width localparam helper.
//   - Sub-module seq_det_sat_counter (CNT_W): inputs inc and clr; outputs count and sat.
//     Same async active-low reset.
//   - The top holds the state register, the table lookup and the out register.
// TESTING
//   1. Default params, en = 1, in = 1,0,1,1,0,1,1 -> out pulses after bit 4 and bit 7;
//      match_count = 2; state after bit 4 = 1.
//   2. OVERLAP = 0, same stream -> single pulse after bit 4; state = 0 after bit 4;
//      match_count = 1.
//   3. reset driven to 0 after in = 1,0,1 (state = 3), then released and in = 1 ->
//      state = 1, no pulse; outputs read 0 asynchronously during reset.
//   4. en = 0 for 3 cycles mid-pattern (state = 2) with in toggling -> state stays 2;
//      resuming with 1,1 -> match.
//   5. CNT_W = 2, 5 matches -> match_count = 3, count_sat = 1.
//      count_clr coincident with the 6th match -> match_count = 0, out still pulses.
//   6. N = 3, PATTERN = 3'b111, in = six 1s -> out high 4 consecutive cycles;
//      match_count = 4.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised sequence detector: KMP transition and failure functions.
package seq_det_pkg;

  localparam int unsigned MAX_N = 32;

  // Width of the matched-prefix register for a pattern of length n.
  function automatic int unsigned state_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Bit k of a pattern-sized vector, without a variable-width bit select.
  function automatic logic pbit(input logic [MAX_N-1:0] v, input int unsigned k);
    logic [MAX_N-1:0] t;
    t = v >> k;
    return t[0];
  endfunction

  // Bit k of the candidate string (prefix followed by the new bit).
  function automatic logic sbit(input logic [MAX_N:0] v, input int unsigned k);
    logic [MAX_N:0] t;
    t = v >> k;
    return t[0];
  endfunction

  // Longest prefix of pattern that is a suffix of (prefix of length len, then b).
  function automatic int unsigned next_len(input logic [MAX_N-1:0] pattern,
                                           input int unsigned n,
                                           input int unsigned len,
                                           input logic b);
    logic [MAX_N:0] s;
    int unsigned    res;
    logic           ok;
    s = '0;
    for (int unsigned j = 0; j <= MAX_N; j++) begin
      if (j < len) s = s | ((MAX_N+1)'(pbit(pattern, n - 1 - j)) << j);
      else if (j == len) s = s | ((MAX_N+1)'(b) << j);
    end
    res = 0;
    for (int unsigned l = 1; l <= MAX_N; l++) begin
      if (l <= len + 1 && l <= n) begin
        ok = 1'b1;
        for (int unsigned i = 0; i < MAX_N; i++) begin
          if (i < l && pbit(pattern, n - 1 - i) != sbit(s, len + 1 - l + i)) ok = 1'b0;
        end
        if (ok) res = l;
      end
    end
    return res;
  endfunction

  // Longest proper prefix of the full pattern that is also its suffix.
  function automatic int unsigned fail_len(input logic [MAX_N-1:0] pattern,
                                           input int unsigned n);
    int unsigned res;
    logic        ok;
    res = 0;
    for (int unsigned l = 1; l < MAX_N; l++) begin
      if (l < n) begin
        ok = 1'b1;
        for (int unsigned i = 0; i < MAX_N; i++) begin
          if (i < l && pbit(pattern, n - 1 - i) != pbit(pattern, l - 1 - i)) ok = 1'b0;
        end
        if (ok) res = l;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating match counter with synchronous clear taking priority over increment.
module seq_det_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count register: clear wins, otherwise increment until all ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != CNT_MAX) begin
      count <= count + CNT_W'(1);
    end
  end

  assign sat = (count == CNT_MAX);

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector: KMP prefix-length state, registered match pulse, saturating count.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned      N       = 4,
  parameter logic [MAX_N-1:0] PATTERN = 32'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  in,
  input  logic                  count_clr,
  output logic                  out,
  output logic [state_w(N)-1:0] state,
  output logic [CNT_W-1:0]      match_count,
  output logic                  count_sat
);

  localparam int unsigned SW = state_w(N);
  localparam int unsigned NS = 2 ** SW;
  localparam int unsigned FL = fail_len(PATTERN, N);

  // Reject unusable parameter combinations at elaboration.
  if (N < 2 || N > MAX_N) begin : g_bad_n
    $error("seq_detector_param: N must be in 2..%0d", MAX_N);
  end
  if ((PATTERN >> N) != '0) begin : g_bad_pattern
    $error("seq_detector_param: PATTERN has bits set above N");
  end

  logic [SW-1:0] nxt_tab [NS][2];
  logic          hit_tab [NS][2];
  logic [SW-1:0] state_d;
  logic          hit_c;

  // Transition table built entirely from constants; rows past N-1 are unreachable.
  for (genvar s = 0; s < NS; s++) begin : g_row
    for (genvar b = 0; b < 2; b++) begin : g_col
      localparam int unsigned L   = (s < N) ? next_len(PATTERN, N, s, 1'(b)) : 0;
      localparam bit          HIT = (L == N);
      localparam int unsigned NXT = HIT ? (OVERLAP ? FL : 0) : L;
      assign nxt_tab[s][b] = SW'(NXT);
      assign hit_tab[s][b] = HIT;
    end
  end

  // Next-state lookup; state holds and no match while sampling is disabled.
  always_comb begin
    state_d = state;
    hit_c   = 1'b0;
    if (en) begin
      state_d = nxt_tab[state][in];
      hit_c   = hit_tab[state][in];
    end
  end

  // State and match-pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= '0;
      out   <= 1'b0;
    end else begin
      state <= state_d;
      out   <= hit_c;
    end
  end

  seq_det_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit_c),
    .clr   (count_clr),
    .count (match_count),
    .sat   (count_sat)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: four detector configurations driven by directed vectors.
module tb_seq_detector_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2, rst3;
  logic en0, en1, en2, en3;
  logic in0, in1, in2, in3;
  logic clr0, clr1, clr2, clr3;
  logic out0, out1, out2, out3;
  logic [1:0] st0, st1, st2, st3;
  logic [7:0] cnt0, cnt1, cnt3;
  logic [1:0] cnt2;
  logic sat0, sat1, sat2, sat3;

  seq_detector_param u0 (
    .clk(clk), .reset(rst0), .en(en0), .in(in0), .count_clr(clr0),
    .out(out0), .state(st0), .match_count(cnt0), .count_sat(sat0));

  seq_detector_param #(.OVERLAP(1'b0)) u1 (
    .clk(clk), .reset(rst1), .en(en1), .in(in1), .count_clr(clr1),
    .out(out1), .state(st1), .match_count(cnt1), .count_sat(sat1));

  seq_detector_param #(.CNT_W(2)) u2 (
    .clk(clk), .reset(rst2), .en(en2), .in(in2), .count_clr(clr2),
    .out(out2), .state(st2), .match_count(cnt2), .count_sat(sat2));

  seq_detector_param #(.N(3), .PATTERN(32'b111)) u3 (
    .clk(clk), .reset(rst3), .en(en3), .in(in3), .count_clr(clr3),
    .out(out3), .state(st3), .match_count(cnt3), .count_sat(sat3));

  typedef struct {
    int    id;
    int    o;
    int    st;
    int    cnt;
    int    sat;
    string tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Compare one expectation against the addressed DUT's outputs.
  task automatic do_check(input exp_t e);
    int o, st, cnt, sat;
    case (e.id)
      0:       begin o = int'(out0); st = int'(st0); cnt = int'(cnt0); sat = int'(sat0); end
      1:       begin o = int'(out1); st = int'(st1); cnt = int'(cnt1); sat = int'(sat1); end
      2:       begin o = int'(out2); st = int'(st2); cnt = int'(cnt2); sat = int'(sat2); end
      default: begin o = int'(out3); st = int'(st3); cnt = int'(cnt3); sat = int'(sat3); end
    endcase
    checks++;
    if (o != e.o || st != e.st || cnt != e.cnt || sat != e.sat) begin
      errors++;
      $display("FAIL %s dut%0d: got out=%0d state=%0d count=%0d sat=%0d, want out=%0d state=%0d count=%0d sat=%0d",
               e.tag, e.id, o, st, cnt, sat, e.o, e.st, e.cnt, e.sat);
    end
  endtask

  task automatic drive(input int id, input int r, input int e, input int b, input int c);
    case (id)
      0:       begin rst0 = 1'(r); en0 = 1'(e); in0 = 1'(b); clr0 = 1'(c); end
      1:       begin rst1 = 1'(r); en1 = 1'(e); in1 = 1'(b); clr1 = 1'(c); end
      2:       begin rst2 = 1'(r); en2 = 1'(e); in2 = 1'(b); clr2 = 1'(c); end
      default: begin rst3 = 1'(r); en3 = 1'(e); in3 = 1'(b); clr3 = 1'(c); end
    endcase
  endtask

  // Drive one cycle of inputs and queue the response expected after the next edge.
  task automatic step(input int id, input int r, input int e, input int b, input int c,
                      input int eo, input int est, input int ecnt, input int esat,
                      input string tag);
    exp_t x;
    @(negedge clk);
    drive(id, r, e, b, c);
    x.id = id; x.o = eo; x.st = est; x.cnt = ecnt; x.sat = esat; x.tag = tag;
    q.push_back(x);
  endtask

  // Assert reset between edges and check that outputs clear without a clock.
  task automatic async_rst(input int id, input string tag);
    exp_t x;
    @(negedge clk);
    case (id)
      0:       rst0 = 1'b0;
      1:       rst1 = 1'b0;
      2:       rst2 = 1'b0;
      default: rst3 = 1'b0;
    endcase
    #1;
    x.id = id; x.o = 0; x.st = 0; x.cnt = 0; x.sat = 0; x.tag = tag;
    do_check(x);
  endtask

  // Monitor: one registered response per clock edge while expectations are pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        do_check(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t r;
    int pc, nc;
    rst0 = 0; rst1 = 0; rst2 = 0; rst3 = 0;
    en0 = 0; en1 = 0; en2 = 0; en3 = 0;
    in0 = 0; in1 = 0; in2 = 0; in3 = 0;
    clr0 = 0; clr1 = 0; clr2 = 0; clr3 = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      r.id = i; r.o = 0; r.st = 0; r.cnt = 0; r.sat = 0; r.tag = "reset_state";
      do_check(r);
    end
    rst0 = 1; rst1 = 1; rst2 = 1; rst3 = 1;

    // 1: default pattern 1011, overlapping
    step(0, 1, 1, 1, 0, 0, 1, 0, 0, "t1_b1");
    step(0, 1, 1, 0, 0, 0, 2, 0, 0, "t1_b2");
    step(0, 1, 1, 1, 0, 0, 3, 0, 0, "t1_b3");
    step(0, 1, 1, 1, 0, 1, 1, 1, 0, "t1_b4_match");
    step(0, 1, 1, 0, 0, 0, 2, 1, 0, "t1_b5");
    step(0, 1, 1, 1, 0, 0, 3, 1, 0, "t1_b6");
    step(0, 1, 1, 1, 0, 1, 1, 2, 0, "t1_b7_match");
    step(0, 1, 0, 0, 0, 0, 1, 2, 0, "t1_idle");

    // 2: non-overlapping
    step(1, 1, 1, 1, 0, 0, 1, 0, 0, "t2_b1");
    step(1, 1, 1, 0, 0, 0, 2, 0, 0, "t2_b2");
    step(1, 1, 1, 1, 0, 0, 3, 0, 0, "t2_b3");
    step(1, 1, 1, 1, 0, 1, 0, 1, 0, "t2_b4_match");
    step(1, 1, 1, 0, 0, 0, 0, 1, 0, "t2_b5");
    step(1, 1, 1, 1, 0, 0, 1, 1, 0, "t2_b6");
    step(1, 1, 1, 1, 0, 0, 1, 1, 0, "t2_b7_nomatch");
    step(1, 1, 0, 0, 0, 0, 1, 1, 0, "t2_idle");

    // 3: async reset mid-sequence
    async_rst(0, "t3_async_a");
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, "t3_hold_a");
    step(0, 1, 1, 1, 0, 0, 1, 0, 0, "t3_b1");
    step(0, 1, 1, 0, 0, 0, 2, 0, 0, "t3_b2");
    step(0, 1, 1, 1, 0, 0, 3, 0, 0, "t3_b3");
    async_rst(0, "t3_async_b");
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, "t3_hold_b");
    step(0, 1, 1, 1, 0, 0, 1, 0, 0, "t3_after");

    // 4: enable low mid-pattern
    step(0, 1, 1, 0, 0, 0, 2, 0, 0, "t4_b0");
    step(0, 1, 0, 1, 0, 0, 2, 0, 0, "t4_off1");
    step(0, 1, 0, 0, 0, 0, 2, 0, 0, "t4_off2");
    step(0, 1, 0, 1, 0, 0, 2, 0, 0, "t4_off3");
    step(0, 1, 1, 1, 0, 0, 3, 0, 0, "t4_b1");
    step(0, 1, 1, 1, 0, 1, 1, 1, 0, "t4_match");
    step(0, 1, 0, 0, 0, 0, 1, 1, 0, "t4_idle");

    // 5: 2-bit counter saturation and clear priority
    step(2, 1, 1, 1, 0, 0, 1, 0, 0, "t5_b1");
    step(2, 1, 1, 0, 0, 0, 2, 0, 0, "t5_b2");
    step(2, 1, 1, 1, 0, 0, 3, 0, 0, "t5_b3");
    step(2, 1, 1, 1, 0, 1, 1, 1, 0, "t5_m1");
    for (int k = 2; k <= 5; k++) begin
      pc = (k - 1 > 3) ? 3 : k - 1;
      nc = (k > 3) ? 3 : k;
      step(2, 1, 1, 0, 0, 0, 2, pc, (pc == 3) ? 1 : 0, "t5_z");
      step(2, 1, 1, 1, 0, 0, 3, pc, (pc == 3) ? 1 : 0, "t5_o");
      step(2, 1, 1, 1, 0, 1, 1, nc, (nc == 3) ? 1 : 0, "t5_m");
    end
    step(2, 1, 1, 0, 0, 0, 2, 3, 1, "t5_z6");
    step(2, 1, 1, 1, 0, 0, 3, 3, 1, "t5_o6");
    step(2, 1, 1, 1, 1, 1, 1, 0, 0, "t5_clr_match");
    step(2, 1, 0, 0, 0, 0, 1, 0, 0, "t5_idle");

    // 6: pattern 111, back-to-back matches
    step(3, 1, 1, 1, 0, 0, 1, 0, 0, "t6_b1");
    step(3, 1, 1, 1, 0, 0, 2, 0, 0, "t6_b2");
    step(3, 1, 1, 1, 0, 1, 2, 1, 0, "t6_m1");
    step(3, 1, 1, 1, 0, 1, 2, 2, 0, "t6_m2");
    step(3, 1, 1, 1, 0, 1, 2, 3, 0, "t6_m3");
    step(3, 1, 1, 1, 0, 1, 2, 4, 0, "t6_m4");
    step(3, 1, 1, 0, 0, 0, 0, 4, 0, "t6_break");
    step(3, 1, 0, 0, 0, 0, 0, 4, 0, "t6_idle");

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
